bp_me_mem_cmd_serializer: RTL and testbench

Upstream neighbour of the BedRock memory-command channel: accepts one memory command per transaction (header plus full-width data) and emits it as a header handshake followed by a stream of narrow data beats. Whether a command carries beats is decided solely by its message type against a payload mask. The default mask selects write and uncached-write commands. The block sits between the CCE/LCE command source and the narrow memory-side link.

---
 rtl/bp_me_mem_cmd_serializer.sv | 143 ++++++++++++++
 tb/tb_bp_me_mem_cmd_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_mem_cmd_serializer.sv
// Memory-command serializer: registers one header+payload command and emits the header, then narrow data beats.
// Optional BP_ME_SERIALIZER_OVERLAP_EN lets beats be offered alongside the pending header.
module bp_me_mem_cmd_serializer
  #(parameter int header_width_p = 64
    , parameter int data_width_p = 512
    , parameter int beat_width_p = 64
    // bit 3 = e_bedrock_mem_uc_wr, bit 1 = e_bedrock_mem_wr
    , parameter logic [15:0] payload_mask_p = 16'b0000_0000_0000_1010
    )
    (input  logic                      clk_i
     , input  logic                      reset_i

     , input  logic [header_width_p-1:0] header_i
     , input  logic [data_width_p-1:0]   data_i
     , input  logic                      v_i
     , output logic                      ready_and_o

     , output logic [header_width_p-1:0] header_o
     , output logic                      header_v_o
     , input  logic                      header_ready_and_i

     , output logic [beat_width_p-1:0]   data_o
     , output logic                      data_v_o
     , input  logic                      data_ready_and_i
     , output logic                      last_o
     );

    localparam int beats_max_lp = data_width_p / beat_width_p;
    localparam int cnt_w_lp     = (beats_max_lp > 1) ? $clog2(beats_max_lp) : 1;
    localparam int beats_w_lp   = $clog2(beats_max_lp + 1);

    typedef enum logic [1:0] {e_ready, e_header, e_data} state_e;

    state_e                    state_q;
    logic                      init_q;
    logic [header_width_p-1:0] header_q;
    logic [data_width_p-1:0]   data_q;
    logic                      has_data_q;
    logic [beats_w_lp-1:0]     beats_q;
    logic [cnt_w_lp-1:0]       cnt_q;

    // Beat count from the size code: at least one beat, never more than the payload holds.
    function automatic logic [beats_w_lp-1:0] beats_f(input logic [2:0] size);
        int n;
        n = (8 << size) / beat_width_p;
        if (n < 1) n = 1;
        if (n > beats_max_lp) n = beats_max_lp;
        return beats_w_lp'(n);
    endfunction

    logic                  has_data_d;
    logic [beats_w_lp-1:0] beats_d;
    logic                  in_fire, hdr_fire, beat_fire, last_beat;

    assign has_data_d = payload_mask_p[header_i[3:0]];
    assign beats_d    = beats_f(header_i[6:4]);

    assign ready_and_o = init_q & (state_q == e_ready);
    assign header_v_o  = (state_q == e_header);

`ifdef BP_ME_SERIALIZER_OVERLAP_EN
    logic data_done_q;
    assign data_v_o = (state_q == e_data)
                    | ((state_q == e_header) & has_data_q & ~data_done_q);
`else
    assign data_v_o = (state_q == e_data);
`endif

    assign last_beat = (beats_w_lp'(cnt_q) == (beats_q - beats_w_lp'(1)));
    assign last_o    = data_v_o & last_beat;
    assign header_o  = header_q;
    assign data_o    = data_q[int'(cnt_q)*beat_width_p +: beat_width_p];

    assign in_fire   = v_i & ready_and_o;
    assign hdr_fire  = header_v_o & header_ready_and_i;
    assign beat_fire = data_v_o & data_ready_and_i;

    // init_q keeps ready low through reset and raises it on the first edge afterwards.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_ready;
            init_q      <= 1'b0;
            header_q    <= '0;
            data_q      <= '0;
            has_data_q  <= 1'b0;
            beats_q     <= '0;
            cnt_q       <= '0;
`ifdef BP_ME_SERIALIZER_OVERLAP_EN
            data_done_q <= 1'b0;
`endif
        end else begin
            init_q <= 1'b1;
            case (state_q)
                e_ready: begin
                    if (in_fire) begin
                        header_q    <= header_i;
                        data_q      <= data_i;
                        has_data_q  <= has_data_d;
                        beats_q     <= beats_d;
                        cnt_q       <= '0;
`ifdef BP_ME_SERIALIZER_OVERLAP_EN
                        data_done_q <= 1'b0;
`endif
                        state_q     <= e_header;
                    end
                end
                e_header: begin
`ifdef BP_ME_SERIALIZER_OVERLAP_EN
                    if (beat_fire) begin
                        if (last_beat) begin
                            cnt_q       <= '0;
                            data_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + cnt_w_lp'(1);
                        end
                    end
                    // Leave only once both the header and every beat have been taken.
                    if (hdr_fire) begin
                        state_q <= (has_data_q & ~data_done_q & ~(beat_fire & last_beat))
                                   ? e_data : e_ready;
                    end
`else
                    if (hdr_fire) begin
                        state_q <= has_data_q ? e_data : e_ready;
                    end
`endif
                end
                e_data: begin
                    if (beat_fire) begin
                        if (last_beat) begin
                            cnt_q   <= '0;
                            state_q <= e_ready;
                        end else begin
                            cnt_q <= cnt_q + cnt_w_lp'(1);
                        end
                    end
                end
                default: state_q <= e_ready;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_me_mem_cmd_serializer.sv
// Directed self-checking bench for bp_me_mem_cmd_serializer (default 64/512/64 configuration).
module tb_bp_me_mem_cmd_serializer;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [63:0]  header_i;
    logic [511:0] data_i;
    logic         v_i;
    logic         ready_and_o;
    logic [63:0]  header_o;
    logic         header_v_o;
    logic         header_ready_and_i;
    logic [63:0]  data_o;
    logic         data_v_o;
    logic         data_ready_and_i;
    logic         last_o;

    int checks = 0;
    int errors = 0;

`ifdef BP_ME_SERIALIZER_OVERLAP_EN
    localparam int OVL = 1;
`else
    localparam int OVL = 0;
`endif

    localparam logic [3:0] T_RD = 4'd0, T_WR = 4'd1, T_UC_RD = 4'd2, T_UC_WR = 4'd3;

    bp_me_mem_cmd_serializer dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .header_i           (header_i),
        .data_i             (data_i),
        .v_i                (v_i),
        .ready_and_o        (ready_and_o),
        .header_o           (header_o),
        .header_v_o         (header_v_o),
        .header_ready_and_i (header_ready_and_i),
        .data_o             (data_o),
        .data_v_o           (data_v_o),
        .data_ready_and_i   (data_ready_and_i),
        .last_o             (last_o)
    );

    always #5 clk = ~clk;

    // Per-cycle trace of one command, indexed by cycles after the accept edge.
    logic        tr_dv   [0:63];
    logic        tr_drdy [0:63];
    logic        tr_last [0:63];
    logic [63:0] tr_do   [0:63];
    logic [63:0] got     [$];
    logic        lasts   [$];
    int          beat_cyc[$];
    int          occ, nhdr, hdr_cyc, ndv;
    logic        acc_ok;
    logic [63:0] hdr_seen;

    function automatic logic [63:0] mk_hdr(input logic [3:0] t, input logic [2:0] s, input logic [56:0] tag);
        return {tag, s, t};
    endfunction

    function automatic logic [511:0] words(input logic [63:0] base);
        logic [511:0] w;
        for (int k = 0; k < 8; k++) w[k*64 +: 64] = base + 64'(k);
        return w;
    endfunction

    task automatic run_cmd(input logic [63:0] hdr, input logic [511:0] dat,
                           input logic [15:0] hpat, input logic [15:0] dpat);
        got.delete(); lasts.delete(); beat_cyc.delete();
        occ = -1; nhdr = 0; hdr_cyc = -1; hdr_seen = '0; ndv = 0;
        for (int i = 0; i < 64; i++) begin
            tr_dv[i] = 1'b0; tr_drdy[i] = 1'b0; tr_last[i] = 1'b0; tr_do[i] = '0;
        end
        @(negedge clk);
        acc_ok = ready_and_o;
        header_i = hdr; data_i = dat; v_i = 1'b1;
        header_ready_and_i = 1'b0; data_ready_and_i = 1'b0;
        @(posedge clk);
        for (int c = 1; c < 64; c++) begin
            @(negedge clk);
            v_i = 1'b0; header_i = '0; data_i = '0;
            if (ready_and_o) begin
                occ = c;
                break;
            end
            header_ready_and_i = hpat[c % 16];
            data_ready_and_i   = dpat[c % 16];
            tr_dv[c] = data_v_o; tr_drdy[c] = data_ready_and_i;
            tr_last[c] = last_o; tr_do[c] = data_o;
            if (data_v_o) ndv++;
            if (header_v_o && header_ready_and_i) begin
                nhdr++; hdr_cyc = c; hdr_seen = header_o;
            end
            if (data_v_o && data_ready_and_i) begin
                got.push_back(data_o); lasts.push_back(last_o); beat_cyc.push_back(c);
            end
            @(posedge clk);
        end
        header_ready_and_i = 1'b1; data_ready_and_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; v_i = 1'b0; header_i = '0; data_i = '0;
        header_ready_and_i = 1'b1; data_ready_and_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ready_and_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_and_o); end
        checks++; if (header_v_o !== 1'b0) begin errors++; $display("FAIL reset_hv: got %b expected 0", header_v_o); end
        checks++; if (data_v_o !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b expected 0", data_v_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", last_o); end
        checks++; if (header_o !== 64'h0) begin errors++; $display("FAIL reset_header: got %h expected 0", header_o); end
        checks++; if (data_o !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_o); end
        reset_i = 1'b0;
        #1;
        checks++; if (ready_and_o !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b expected 0", ready_and_o); end
        @(negedge clk);
        checks++; if (ready_and_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", ready_and_o); end
    endtask

    task automatic test_rd();
        logic [63:0] h;
        h = mk_hdr(T_RD, 3'd6, 57'h1234567);
        run_cmd(h, words(64'h55), 16'hFFFF, 16'hFFFF);
        checks++; if (acc_ok !== 1'b1) begin errors++; $display("FAIL rd_accept: got %b expected 1", acc_ok); end
        checks++; if (nhdr !== 1) begin errors++; $display("FAIL rd_nhdr: got %0d expected 1", nhdr); end
        checks++; if (hdr_seen !== h) begin errors++; $display("FAIL rd_header: got %h expected %h", hdr_seen, h); end
        checks++; if (ndv !== 0) begin errors++; $display("FAIL rd_dv_cycles: got %0d expected 0", ndv); end
        checks++; if (occ !== 2) begin errors++; $display("FAIL rd_occ: got %0d expected 2", occ); end
    endtask

    task automatic test_wr();
        logic [63:0] h;
        h = mk_hdr(T_WR, 3'd6, 57'hABC);
        run_cmd(h, words(64'h0), 16'hFFFF, 16'hFFFF);
        checks++; if (acc_ok !== 1'b1) begin errors++; $display("FAIL wr_accept: got %b expected 1", acc_ok); end
        checks++; if (hdr_seen !== h) begin errors++; $display("FAIL wr_header: got %h expected %h", hdr_seen, h); end
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL wr_nbeats: got %0d expected 8", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            checks++; if (got[k] !== 64'(k)) begin errors++; $display("FAIL wr_beat%0d: got %h expected %h", k, got[k], 64'(k)); end
            checks++; if (lasts[k] !== (k == 7)) begin errors++; $display("FAIL wr_last%0d: got %b expected %b", k, lasts[k], (k == 7)); end
        end
        if (beat_cyc.size() > 0) begin
            checks++; if (beat_cyc[0] !== 2 - OVL) begin errors++; $display("FAIL wr_first_beat_cyc: got %0d expected %0d", beat_cyc[0], 2 - OVL); end
        end
        checks++; if (occ !== 10 - OVL) begin errors++; $display("FAIL wr_occ: got %0d expected %0d", occ, 10 - OVL); end
    endtask

    task automatic test_uc_wr();
        logic [511:0] d;
        d = '1;
        d[63:0] = 64'hDEADBEEF;
        run_cmd(mk_hdr(T_UC_WR, 3'd2, 57'h7), d, 16'hFFFF, 16'hFFFF);
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL ucwr_nbeats: got %0d expected 1", got.size()); end
        if (got.size() > 0) begin
            checks++; if (got[0] !== 64'h00000000DEADBEEF) begin errors++; $display("FAIL ucwr_beat: got %h expected 00000000deadbeef", got[0]); end
            checks++; if (lasts[0] !== 1'b1) begin errors++; $display("FAIL ucwr_last: got %b expected 1", lasts[0]); end
        end
        checks++; if (occ !== 3 - OVL) begin errors++; $display("FAIL ucwr_occ: got %0d expected %0d", occ, 3 - OVL); end
    endtask

    task automatic test_sizes();
        // size 7 exceeds the 64-byte payload and clamps to 8 beats
        run_cmd(mk_hdr(T_WR, 3'd7, 57'h9), words(64'd100), 16'hFFFF, 16'hFFFF);
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL clamp_nbeats: got %0d expected 8", got.size()); end
        if (got.size() == 8) begin
            checks++; if (got[7] !== 64'd107) begin errors++; $display("FAIL clamp_beat7: got %h expected %h", got[7], 64'd107); end
        end
        checks++; if (occ !== 10 - OVL) begin errors++; $display("FAIL clamp_occ: got %0d expected %0d", occ, 10 - OVL); end
        // size 4 = 16 bytes = 2 beats
        run_cmd(mk_hdr(T_WR, 3'd4, 57'h3), words(64'd20), 16'hFFFF, 16'hFFFF);
        checks++; if (got.size() !== 2) begin errors++; $display("FAIL sz4_nbeats: got %0d expected 2", got.size()); end
        if (got.size() == 2) begin
            checks++; if (got[1] !== 64'd21 || lasts[1] !== 1'b1 || lasts[0] !== 1'b0) begin
                errors++; $display("FAIL sz4_beat1: got %h/%b%b expected %h/01", got[1], lasts[0], lasts[1], 64'd21); end
        end
        // types outside the mask never raise data valid
        run_cmd(mk_hdr(T_UC_RD, 3'd6, 57'h4), words(64'd1), 16'hFFFF, 16'hFFFF);
        checks++; if (ndv !== 0 || occ !== 2) begin errors++; $display("FAIL ucrd_nodata: got dv=%0d occ=%0d expected dv=0 occ=2", ndv, occ); end
        run_cmd(mk_hdr(4'hF, 3'd6, 57'h5), words(64'd1), 16'hFFFF, 16'hFFFF);
        checks++; if (ndv !== 0 || occ !== 2) begin errors++; $display("FAIL type15_nodata: got dv=%0d occ=%0d expected dv=0 occ=2", ndv, occ); end
    endtask

    task automatic test_backpressure();
        int exp_cyc [8] = '{3, 4, 7, 8, 11, 12, 15, 16};
        run_cmd(mk_hdr(T_WR, 3'd6, 57'h66), words(64'h200), 16'hFFFF, 16'h9999);
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL bp_nbeats: got %0d expected 8", got.size()); end
        for (int k = 0; k < got.size() && k < 8; k++) begin
            checks++; if (got[k] !== 64'h200 + 64'(k) || lasts[k] !== (k == 7) || beat_cyc[k] !== exp_cyc[k]) begin
                errors++; $display("FAIL bp_beat%0d: got %h last=%b cyc=%0d expected %h last=%b cyc=%0d",
                                   k, got[k], lasts[k], beat_cyc[k], 64'h200 + 64'(k), (k == 7), exp_cyc[k]); end
        end
        for (int c = 1; c < 62; c++) begin
            if (tr_dv[c] && !tr_drdy[c]) begin
                checks++; if (tr_dv[c+1] !== 1'b1 || tr_do[c+1] !== tr_do[c] || tr_last[c+1] !== tr_last[c]) begin
                    errors++; $display("FAIL bp_hold_c%0d: got dv=%b %h last=%b expected dv=1 %h last=%b",
                                       c + 1, tr_dv[c+1], tr_do[c+1], tr_last[c+1], tr_do[c], tr_last[c]); end
            end
        end
        checks++; if (occ !== 17) begin errors++; $display("FAIL bp_occ: got %0d expected 17", occ); end
    endtask

    task automatic test_reset_midstream();
        logic        seen;
        logic [63:0] h;
        @(negedge clk);
        header_i = mk_hdr(T_WR, 3'd6, 57'h77); data_i = words(64'h0); v_i = 1'b1;
        header_ready_and_i = 1'b1; data_ready_and_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (data_v_o && data_o == 64'd3) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_beat3_seen: got %b expected 1", seen); end
        #1 reset_i = 1'b1;
        #1;
        checks++; if (data_v_o !== 1'b0 || header_v_o !== 1'b0 || last_o !== 1'b0) begin
            errors++; $display("FAIL mid_valids: got dv=%b hv=%b last=%b expected 0 0 0", data_v_o, header_v_o, last_o); end
        checks++; if (ready_and_o !== 1'b0 || data_o !== 64'h0) begin
            errors++; $display("FAIL mid_ready_data: got rdy=%b data=%h expected 0 0", ready_and_o, data_o); end
        @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
        checks++; if (ready_and_o !== 1'b1 || data_v_o !== 1'b0 || header_v_o !== 1'b0) begin
            errors++; $display("FAIL mid_after: got rdy=%b dv=%b hv=%b expected 1 0 0", ready_and_o, data_v_o, header_v_o); end
        h = mk_hdr(T_RD, 3'd6, 57'h88);
        run_cmd(h, words(64'h0), 16'hFFFF, 16'hFFFF);
        checks++; if (nhdr !== 1 || hdr_seen !== h || got.size() !== 0 || occ !== 2) begin
            errors++; $display("FAIL mid_no_replay: got nhdr=%0d hdr=%h beats=%0d occ=%0d expected 1 %h 0 2",
                               nhdr, hdr_seen, got.size(), occ, h); end
    endtask

`ifdef BP_ME_SERIALIZER_OVERLAP_EN
    task automatic test_overlap();
        run_cmd(mk_hdr(T_WR, 3'd3, 57'h99), words(64'd40), 16'hFFC1, 16'hFFFF);
        checks++; if (got.size() !== 1) begin errors++; $display("FAIL ovl_nbeats: got %0d expected 1", got.size()); end
        if (got.size() == 1) begin
            checks++; if (got[0] !== 64'd40 || lasts[0] !== 1'b1 || beat_cyc[0] !== 1) begin
                errors++; $display("FAIL ovl_beat: got %h last=%b cyc=%0d expected %h 1 1", got[0], lasts[0], beat_cyc[0], 64'd40); end
        end
        checks++; if (hdr_cyc !== 6) begin errors++; $display("FAIL ovl_hdr_cyc: got %0d expected 6", hdr_cyc); end
        checks++; if (occ !== 7) begin errors++; $display("FAIL ovl_occ: got %0d expected 7", occ); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rd();
        test_wr();
        test_uc_wr();
        test_sizes();
        test_backpressure();
        test_reset_midstream();
`ifdef BP_ME_SERIALIZER_OVERLAP_EN
        test_overlap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
